// File: rtl/draw_text_box_pkg.sv
// Types and helpers for the text-box renderer: a packed copy of the vga_if
// fields, used to carry a pixel through the delay pipe, and the SCALE log2.
package draw_text_box_pkg;

  typedef struct packed {
    logic [vga_pkg::VCOUNT_W-1:0] vcount;
    logic                         vsync;
    logic                         vblnk;
    logic [vga_pkg::HCOUNT_W-1:0] hcount;
    logic                         hsync;
    logic                         hblnk;
    logic [vga_pkg::RGB_W-1:0]    rgb;
  } vga_bus_t;

  localparam int unsigned VgaBusW = $bits(vga_bus_t);

  // SCALE is restricted to 1, 2 or 4.
  function automatic int unsigned scale_log2(input int unsigned scale);
    case (scale)
      2:       return 1;
      4:       return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants: counter widths, colour depth, glyph geometry
// and the default text colours used by the text overlay stages.
package vga_pkg;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 11;
  localparam int unsigned RGB_W    = 12;

  // Glyph cell geometry of the font ROM.
  localparam int unsigned CHAR_W          = 8;
  localparam int unsigned CHAR_H          = 16;
  localparam int unsigned CHAR_BIT_LENGTH = 8;

  localparam logic [RGB_W-1:0] TEXT_COLOR    = 12'hFF0;
  localparam logic [RGB_W-1:0] TEXT_BG_COLOR = 12'h00F;

endpackage

// File: rtl/vga_if.sv
// VGA timing/colour bundle passed between pipeline stages.
//   in  : consumer view (all fields inputs)
//   out : producer view (all fields outputs)
interface vga_if;

  logic [vga_pkg::VCOUNT_W-1:0] vcount;
  logic                         vsync;
  logic                         vblnk;
  logic [vga_pkg::HCOUNT_W-1:0] hcount;
  logic                         hsync;
  logic                         hblnk;
  logic [vga_pkg::RGB_W-1:0]    rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/delay.sv
// Fixed-length shift-register delay with synchronous active-low clear.
//   clk, rst_n : clock, synchronous active-low reset (clears every stage)
//   din_i      : WIDTH-bit input
//   dout_o     : din_i delayed by CLK_DEL cycles
module delay #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CLK_DEL); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < int'(CLK_DEL); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/text_blink_ctrl.sv
// Frame-synchronous cursor control for the text box.
//   clk, rst_n      : pixel clock, synchronous active-low reset
//   vsync_i         : vsync of the incoming stream; rising edge = frame start
//   cursor_*_i      : requested cursor enable/position, latched at frame start
//   cursor_vis_en_o : cursor should be drawn this frame (enabled, blink on,
//                     position inside the grid)
//   cursor_col_o/row_o : latched cursor position
module text_blink_ctrl #(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 16,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vsync_i,
  input  logic                    cursor_en_i,
  input  logic [$clog2(COLS)-1:0] cursor_col_i,
  input  logic [$clog2(ROWS)-1:0] cursor_row_i,
  output logic                    cursor_vis_en_o,
  output logic [$clog2(COLS)-1:0] cursor_col_o,
  output logic [$clog2(ROWS)-1:0] cursor_row_o
);

  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(BLINK_FRAMES - 1);
  // One extra bit so COLS/ROWS are representable for the range check.
  localparam logic [ColW:0]   ColsLim = (ColW + 1)'(COLS);
  localparam logic [RowW:0]   RowsLim = (RowW + 1)'(ROWS);

  logic            vsync_q;
  logic            frame_start;
  logic [CntW-1:0] frame_cnt_d, frame_cnt_q;
  logic            blink_phase_d, blink_phase_q;
  logic            cur_en_d, cur_en_q;
  logic [ColW-1:0] cur_col_d, cur_col_q;
  logic [RowW-1:0] cur_row_d, cur_row_q;

  always_comb begin
    frame_start   = vsync_i & ~vsync_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    cur_en_d      = cur_en_q;
    cur_col_d     = cur_col_q;
    cur_row_d     = cur_row_q;
    if (frame_start) begin
      cur_en_d  = cursor_en_i;
      cur_col_d = cursor_col_i;
      cur_row_d = cursor_row_i;
      if (frame_cnt_q == CntMax) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      cur_en_q      <= 1'b0;
      cur_col_q     <= '0;
      cur_row_q     <= '0;
    end else begin
      vsync_q       <= vsync_i;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      cur_en_q      <= cur_en_d;
      cur_col_q     <= cur_col_d;
      cur_row_q     <= cur_row_d;
    end
  end

  assign cursor_vis_en_o = cur_en_q & blink_phase_q
                         & ({1'b0, cur_col_q} < ColsLim)
                         & ({1'b0, cur_row_q} < RowsLim);
  assign cursor_col_o    = cur_col_q;
  assign cursor_row_o    = cur_row_q;

endmodule

// File: rtl/draw_text_box.sv
// Text-box overlay stage: renders a COLS x ROWS grid of 8x16 glyphs at
// (X_POS, Y_POS), magnified by SCALE, with optional opaque background and a
// blinking cursor. Every vga_if field is delayed by 4 cycles.
//   clk, rst_n    : pixel clock, synchronous active-low reset
//   char_xy_o     : text-RAM address {row, col} (1 cycle after the pixel)
//   char_line_o   : font-ROM line index (2 cycles after the pixel)
//   char_pixels_i : font-ROM glyph line, MSB leftmost (3 cycles after)
//   cursor_*_i    : cursor enable/position, taken at frame start
//   vga_i / vga_o : incoming and outgoing pixel stream
module draw_text_box
  import draw_text_box_pkg::*;
#(
  parameter int unsigned               X_POS        = 0,
  parameter int unsigned               Y_POS        = 0,
  parameter int unsigned               COLS         = 16,
  parameter int unsigned               ROWS         = 16,
  parameter int unsigned               SCALE        = 1,
  parameter bit                        BG_EN        = 1'b0,
  parameter logic [vga_pkg::RGB_W-1:0] TEXT_COLOR   = vga_pkg::TEXT_COLOR,
  parameter logic [vga_pkg::RGB_W-1:0] BG_COLOR     = vga_pkg::TEXT_BG_COLOR,
  parameter int unsigned               BLINK_FRAMES = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [7:0]                           char_pixels_i,
  output logic [3:0]                           char_line_o,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0] char_xy_o,
  input  logic                                 cursor_en_i,
  input  logic [$clog2(COLS)-1:0]              cursor_col_i,
  input  logic [$clog2(ROWS)-1:0]              cursor_row_i,
  vga_if.in                                    vga_i,
  vga_if.out                                   vga_o
);

  localparam int unsigned ColW      = $clog2(COLS);
  localparam int unsigned RowW      = $clog2(ROWS);
  localparam int unsigned ScaleLog2 = scale_log2(SCALE);
  localparam int          XEnd      = int'(X_POS + COLS * vga_pkg::CHAR_W * SCALE);
  localparam int          YEnd      = int'(Y_POS + ROWS * vga_pkg::CHAR_H * SCALE);

  // Bounds are checked on the raw counters, so pixels left/above the box can
  // never alias into it through a negative offset.
  function automatic logic in_box(input int h, input int v);
    return (h >= int'(X_POS)) && (h < XEnd) && (v >= int'(Y_POS)) && (v < YEnd);
  endfunction

  // Stage 0: address generation from the undelayed pixel.
  vga_bus_t             bus_in;
  int                   hx_in, vy_in;
  logic [RowW+ColW-1:0] char_xy_d, char_xy_q;
  logic [3:0]           line_d, line_q;

  always_comb begin
    bus_in.vcount = vga_i.vcount;
    bus_in.vsync  = vga_i.vsync;
    bus_in.vblnk  = vga_i.vblnk;
    bus_in.hcount = vga_i.hcount;
    bus_in.hsync  = vga_i.hsync;
    bus_in.hblnk  = vga_i.hblnk;
    bus_in.rgb    = vga_i.rgb;

    hx_in     = int'(vga_i.hcount) - int'(X_POS);
    vy_in     = int'(vga_i.vcount) - int'(Y_POS);
    char_xy_d = '0;
    line_d    = '0;
    if (in_box(int'(vga_i.hcount), int'(vga_i.vcount))) begin
      char_xy_d = {RowW'(vy_in >> (4 + ScaleLog2)), ColW'(hx_in >> (3 + ScaleLog2))};
      line_d    = 4'(vy_in >> ScaleLog2);
    end
  end

  // The leading 1 marks real pixels; it shifts in behind the cleared stages
  // after reset so the output stays black until the pipe has refilled.
  logic [VgaBusW:0] pipe_out;
  logic             valid_d3;
  vga_bus_t         bus_d3;

  delay #(
    .WIDTH  (VgaBusW + 1),
    .CLK_DEL(3)
  ) u_vga_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i ({1'b1, bus_in}),
    .dout_o(pipe_out)
  );

  assign valid_d3 = pipe_out[VgaBusW];
  assign bus_d3   = pipe_out[VgaBusW-1:0];

  delay #(
    .WIDTH  (4),
    .CLK_DEL(1)
  ) u_line_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i (line_q),
    .dout_o(char_line_o)
  );

  logic            cursor_vis;
  logic [ColW-1:0] cur_col;
  logic [RowW-1:0] cur_row;

  text_blink_ctrl #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk            (clk),
    .rst_n          (rst_n),
    .vsync_i        (vga_i.vsync),
    .cursor_en_i    (cursor_en_i),
    .cursor_col_i   (cursor_col_i),
    .cursor_row_i   (cursor_row_i),
    .cursor_vis_en_o(cursor_vis),
    .cursor_col_o   (cur_col),
    .cursor_row_o   (cur_row)
  );

  // Stage 3: colour selection once the glyph line has arrived.
  int              hx3, vy3;
  logic            box3;
  logic [ColW-1:0] col3;
  logic [RowW-1:0] row3;
  logic [2:0]      bit_idx;
  logic            glyph_on;
  logic            cursor_cell;
  vga_bus_t        out_d, out_q;

  always_comb begin
    hx3         = int'(bus_d3.hcount) - int'(X_POS);
    vy3         = int'(bus_d3.vcount) - int'(Y_POS);
    box3        = in_box(int'(bus_d3.hcount), int'(bus_d3.vcount));
    col3        = ColW'(hx3 >> (3 + ScaleLog2));
    row3        = RowW'(vy3 >> (4 + ScaleLog2));
    bit_idx     = 3'(hx3 >> ScaleLog2);
    glyph_on    = char_pixels_i[3'd7 - bit_idx];
    cursor_cell = cursor_vis & (col3 == cur_col) & (row3 == cur_row);

    out_d = bus_d3;
    if (!valid_d3) begin
      out_d = '0;
    end else if (bus_d3.hblnk | bus_d3.vblnk) begin
      out_d.rgb = '0;
    end else if (box3) begin
      if (glyph_on)        out_d.rgb = cursor_cell ? BG_COLOR : TEXT_COLOR;
      else if (cursor_cell) out_d.rgb = TEXT_COLOR;
      else if (BG_EN)      out_d.rgb = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_xy_q <= '0;
      line_q    <= '0;
      out_q     <= '0;
    end else begin
      char_xy_q <= char_xy_d;
      line_q    <= line_d;
      out_q     <= out_d;
    end
  end

  assign char_xy_o    = char_xy_q;
  assign vga_o.vcount = out_q.vcount;
  assign vga_o.vsync  = out_q.vsync;
  assign vga_o.vblnk  = out_q.vblnk;
  assign vga_o.hcount = out_q.hcount;
  assign vga_o.hsync  = out_q.hsync;
  assign vga_o.hblnk  = out_q.hblnk;
  assign vga_o.rgb    = out_q.rgb;

endmodule
